// File: rtl/dial_cmd_sequencer_if.sv
// Character-stream and dial-datapath signals of dial_cmd_sequencer.
// cmd_count is present only when DIAL_CMD_COUNT_EN is defined.
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

interface dial_cmd_sequencer_if;
  logic                   in_valid;
  logic                   in_ready;
  logic [7:0]             in_char;
  logic                   in_last;
  logic                   dial_en;
  logic                   dial_dir;
  logic [`DATA_WIDTH-1:0] dial_rot;
  logic [`DATA_WIDTH-1:0] dial_zeros;
  logic [`DATA_WIDTH-1:0] result;
  logic                   done;
  logic                   err;
`ifdef DIAL_CMD_COUNT_EN
  logic [`DATA_WIDTH-1:0] cmd_count;
`endif

  modport master (
`ifdef DIAL_CMD_COUNT_EN
    input  cmd_count,
`endif
    output in_valid, in_char, in_last, dial_zeros,
    input  in_ready, dial_en, dial_dir, dial_rot, result, done, err
  );

  modport slave (
`ifdef DIAL_CMD_COUNT_EN
    output cmd_count,
`endif
    input  in_valid, in_char, in_last, dial_zeros,
    output in_ready, dial_en, dial_dir, dial_rot, result, done, err
  );
endinterface

// File: rtl/dial_cmd_sequencer.sv
// Parses an ASCII "L<n>\n" / "R<n>\n" stream into one-cycle dial rotation strobes
// and captures the final zero count. Optional cmd_count output: DIAL_CMD_COUNT_EN.
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

module dial_cmd_sequencer #(
  parameter int MAX_DIGITS = 5
) (
  input logic           clock,
  input logic           reset,
  dial_cmd_sequencer_if.slave bus
);
  localparam int W  = `DATA_WIDTH;
  localparam int CW = $clog2(MAX_DIGITS + 1);
  localparam logic [7:0] CH_L  = 8'h4C;
  localparam logic [7:0] CH_R  = 8'h52;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_CR = 8'h0D;

  typedef enum logic [2:0] {S_IDLE, S_NUM, S_ISSUE, S_FINISH, S_DONE} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   acc_q, acc_d;
  logic [W-1:0]   rot_q, rot_d;
  logic [W-1:0]   result_q, result_d;
  logic [CW-1:0]  ndig_q, ndig_d;
  logic           dir_q, dir_d;
  logic           out_dir_q, out_dir_d;
  logic           last_q, last_d;
  logic           en_q, en_d;
  logic           err_q, err_d;
  logic           done_q, done_d;

  logic           xfer;
  logic           is_digit;
  logic           issue;
  logic [2*W-1:0] acc_wide;
  logic [2*W-1:0] prod;

  assign bus.in_ready = !reset && (state_q == S_IDLE || state_q == S_NUM);
  assign xfer         = bus.in_valid && bus.in_ready;
  assign is_digit     = (bus.in_char >= 8'h30) && (bus.in_char <= 8'h39);
  assign acc_wide     = {{W{1'b0}}, acc_q};
  // acc*10 + digit at double width so overflow is visible in the upper half
  assign prod         = (acc_wide << 3) + (acc_wide << 1) + {{(2*W-4){1'b0}}, bus.in_char[3:0]};

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    rot_d     = rot_q;
    result_d  = result_q;
    ndig_d    = ndig_q;
    dir_d     = dir_q;
    out_dir_d = out_dir_q;
    last_d    = last_q;
    en_d      = 1'b0;
    err_d     = err_q;
    done_d    = done_q;
    issue     = 1'b0;

    if (xfer && bus.in_last) last_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (xfer) begin
          if (bus.in_char == CH_L || bus.in_char == CH_R) begin
            dir_d   = (bus.in_char == CH_L);
            acc_d   = '0;
            ndig_d  = '0;
            state_d = S_NUM;
          end else if (bus.in_char != CH_LF && bus.in_char != CH_CR) begin
            err_d = 1'b1;
          end
          if (bus.in_last) state_d = S_FINISH;
        end
      end
      S_NUM: begin
        if (xfer) begin
          if (is_digit) begin
            if (ndig_q == CW'(MAX_DIGITS)) begin
              err_d = 1'b1;
            end else begin
              ndig_d = ndig_q + 1'b1;
              if (|prod[2*W-1:W]) begin
                acc_d = '1;
                err_d = 1'b1;
              end else begin
                acc_d = prod[W-1:0];
              end
            end
            // a digit always leaves at least one digit on record
            if (bus.in_last) issue = 1'b1;
          end else if (bus.in_char == CH_LF && ndig_q != '0) begin
            issue = 1'b1;
          end else begin
            err_d   = 1'b1;
            state_d = bus.in_last ? S_FINISH : S_IDLE;
          end
        end
      end
      S_ISSUE:  state_d = last_q ? S_FINISH : S_IDLE;
      S_FINISH: begin
        result_d = bus.dial_zeros;
        done_d   = 1'b1;
        state_d  = S_DONE;
      end
      S_DONE:   state_d = S_DONE;
      default:  state_d = S_IDLE;
    endcase

    if (issue) begin
      state_d   = S_ISSUE;
      en_d      = 1'b1;
      rot_d     = acc_d;
      out_dir_d = dir_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      rot_q     <= '0;
      result_q  <= '0;
      ndig_q    <= '0;
      dir_q     <= 1'b0;
      out_dir_q <= 1'b0;
      last_q    <= 1'b0;
      en_q      <= 1'b0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      rot_q     <= rot_d;
      result_q  <= result_d;
      ndig_q    <= ndig_d;
      dir_q     <= dir_d;
      out_dir_q <= out_dir_d;
      last_q    <= last_d;
      en_q      <= en_d;
      err_q     <= err_d;
      done_q    <= done_d;
    end
  end

  assign bus.dial_en  = en_q;
  assign bus.dial_dir = out_dir_q;
  assign bus.dial_rot = rot_q;
  assign bus.result   = result_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;

`ifdef DIAL_CMD_COUNT_EN
  logic [W-1:0] cmd_count_q, cmd_count_d;

  always_comb begin
    cmd_count_d = cmd_count_q;
    if (en_q) cmd_count_d = cmd_count_q + {{(W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clock) begin
    if (reset) cmd_count_q <= '0;
    else       cmd_count_q <= cmd_count_d;
  end

  assign bus.cmd_count = cmd_count_q;
`endif
endmodule
